// File: rtl/otter_fetch_if.sv
// otter_fetch_if -- instruction fetch bundle between the fetch stage, its
// instruction memory port and the decode stage.
//   slave  : the fetch block (otter_fetch)
//   master : the environment (decode, branch unit and memory port 1)
// Signals:
//   STALL, REDIRECT, REDIRECT_PC  control from decode / branch unit
//   MEM_DOUT1                     registered read data from memory port 1
//   MEM_RDEN1, MEM_ADDR1          read request to memory port 1 (word address)
//   IF_PC, IF_INSTR, IF_VALID     instruction presented to decode
//   FETCH_ERR, FETCH_CNT          sticky misaligned-redirect flag, accept count
interface otter_fetch_if;
  logic        STALL;
  logic        REDIRECT;
  logic [31:0] REDIRECT_PC;
  logic [31:0] MEM_DOUT1;
  logic        MEM_RDEN1;
  logic [13:0] MEM_ADDR1;
  logic [31:0] IF_PC;
  logic [31:0] IF_INSTR;
  logic        IF_VALID;
  logic        FETCH_ERR;
  logic [31:0] FETCH_CNT;

  modport slave (
    input  STALL, REDIRECT, REDIRECT_PC, MEM_DOUT1,
    output MEM_RDEN1, MEM_ADDR1, IF_PC, IF_INSTR, IF_VALID, FETCH_ERR, FETCH_CNT
  );

  modport master (
    output STALL, REDIRECT, REDIRECT_PC, MEM_DOUT1,
    input  MEM_RDEN1, MEM_ADDR1, IF_PC, IF_INSTR, IF_VALID, FETCH_ERR, FETCH_CNT
  );
endinterface

// File: rtl/otter_fetch.sv
// otter_fetch -- single-issue instruction fetch stage for a memory port with
// one cycle of registered read latency.
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset
//   bus  otter_fetch_if.slave (memory request/response, decode handshake,
//        redirect input, error flag and accepted-instruction counter)
// Parameter:
//   RESET_PC  byte address of the first fetch after reset
module otter_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         RST,
  otter_fetch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  state_t      state_reg;
  logic [31:0] pc_req_reg;     // next address to request
  logic [31:0] pc_resp_reg;    // address of the outstanding / held response
  logic        resp_valid_reg;
  logic        fetch_err_reg;
  logic [31:0] fetch_cnt_reg;

  logic        fire;
  logic        if_valid;
  logic        accept;
  logic        redirect_misaligned;

  // A request goes out only when running and neither stalled nor redirected;
  // with STALL=1 the memory holds its output, so the response stays on
  // IF_INSTR without a re-read.
  assign fire                = (state_reg == RUN) && !bus.STALL && !bus.REDIRECT;
  assign if_valid            = resp_valid_reg && (state_reg == RUN);
  // An instruction presented in a redirect cycle is squashed, not counted.
  assign accept              = if_valid && !bus.STALL && !bus.REDIRECT;
  assign redirect_misaligned = |bus.REDIRECT_PC[1:0];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= IDLE;
      pc_req_reg     <= RESET_PC;
      pc_resp_reg    <= 32'h0;
      resp_valid_reg <= 1'b0;
      fetch_err_reg  <= 1'b0;
      fetch_cnt_reg  <= 32'h0;
    end else begin
      if (bus.REDIRECT) begin
        // Redirect wins over stall and over every state, including ERR.
        pc_req_reg     <= bus.REDIRECT_PC;
        resp_valid_reg <= 1'b0;
        if (redirect_misaligned) begin
          state_reg     <= ERR;
          fetch_err_reg <= 1'b1;
        end else begin
          state_reg     <= RUN;
          fetch_err_reg <= 1'b0;
        end
      end else begin
        case (state_reg)
          IDLE: state_reg <= RUN;
          RUN: begin
            if (!bus.STALL) begin
              pc_resp_reg    <= pc_req_reg;
              resp_valid_reg <= 1'b1;
              pc_req_reg     <= pc_req_reg + 32'd4;
            end
          end
          ERR: state_reg <= ERR;
          default: state_reg <= IDLE;
        endcase
      end

      if (accept) begin
        fetch_cnt_reg <= fetch_cnt_reg + 32'd1;
      end
    end
  end

  assign bus.MEM_RDEN1 = fire;
  assign bus.MEM_ADDR1 = pc_req_reg[15:2];
  assign bus.IF_PC     = pc_resp_reg;
  assign bus.IF_INSTR  = bus.MEM_DOUT1;
  assign bus.IF_VALID  = if_valid;
  assign bus.FETCH_ERR = fetch_err_reg;
  assign bus.FETCH_CNT = fetch_cnt_reg;

endmodule
